snoop_bus_arbiter: RTL and testbench

- Serialises coherence transactions from 4 cores onto one shared snoop bus, in front of the per-core MESI cache arrays.
- Grants one requester round-robin and broadcasts its BusRd/BusRdX/BusUpgr to the other cores.
- Collects snoop hit/dirty responses, sequences the dirty-line writeback and the memory fill, then returns the MESI fill state to the requester.

---
 rtl/snoop_bus_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the shared coherence snoop bus for 4 cores.
// Grants one requester, broadcasts its BusRd/BusRdX/BusUpgr, gathers snoop
// hit/dirty responses, sequences the dirty writeback and memory fill, and
// returns the MESI fill state to the owner with a one-cycle done pulse.
// Optional watchdog on the WB/MEM waits: define SNOOP_TIMEOUT_EN.
module snoop_bus_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int SNOOP_LAT   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [7:0]            req_op,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            grant,
  output logic                  snoop_valid,
  output logic [1:0]            snoop_op,
  output logic [ADDR_W-1:0]     snoop_addr,
  output logic [1:0]            snoop_src,
  input  logic [3:0]            snoop_hit,
  input  logic [3:0]            snoop_dirty,
  input  logic                  wb_done,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  output logic [3:0]            done,
  output logic [1:0]            fill_state,
  output logic                  err
);

  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_UPGR = 2'b11;

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_I = 2'b11;

  if (SNOOP_LAT < 1 || SNOOP_LAT > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("snoop_bus_arbiter: SNOOP_LAT must be 1..15 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_WB    = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          rr_ptr;
  logic [3:0]          lat_cnt;
  logic                lat_last;
  logic [3:0]          hit_m;
  logic [3:0]          dirty_now;
  logic [3:0]          elig;
  logic [2:0]          pick;
  logic [1:0]          pick_op;
  logic [ADDR_W-1:0]   pick_addr;

  // Round-robin search starting just after the last owner; {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    // Walk farthest offset first so the nearest eligible index wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (cand[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // MESI state to install in the owner once the transaction resolves.
  function automatic logic [1:0] fill_of(input logic [1:0] op, input logic [3:0] sharers);
    if (op == OP_RD) return (sharers != 4'b0000) ? MESI_S : MESI_E;
    return MESI_M;
  endfunction

  assign lat_last  = (lat_cnt == 4'(SNOOP_LAT));
  assign dirty_now = snoop_dirty & ~grant;

`ifdef SNOOP_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_last;
  logic             tmo_fire;
  logic             timed_out;

  assign tmo_last = ((tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT_CYC));
`endif

  // Eligibility, arbitration pick and the winner's op/address.
  always_comb begin
    elig      = 4'b0000;
    pick_op   = 2'b00;
    pick_addr = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = req[i] & (req_op[2*i +: 2] != 2'b00);
    end
    pick = rr_pick(elig, rr_ptr);
    for (int i = 0; i < 4; i++) begin
      if (pick[1:0] == 2'(i)) begin
        pick_op   = req_op[2*i +: 2];
        pick_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    snoop_valid = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    done        = 4'b0000;
    fill_state  = MESI_I;
    err         = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
    tmo_fire    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick[2]) state_nxt = S_SNOOP;
      end
      S_SNOOP: begin
        snoop_valid = (lat_cnt == 4'd0);
        if (lat_last) begin
          if (dirty_now != 4'b0000)    state_nxt = S_WB;
          else if (snoop_op == OP_UPGR) state_nxt = S_DONE;
          else                          state_nxt = S_MEM;
        end
      end
      S_WB: begin
        if (wb_done) begin
          state_nxt = (snoop_op == OP_UPGR) ? S_DONE : S_MEM;
        end
`ifdef SNOOP_TIMEOUT_EN
        else if (tmo_last) begin
          state_nxt = S_DONE;
          tmo_fire  = 1'b1;
        end
`endif
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = snoop_addr;
        if (mem_ack) begin
          state_nxt = S_DONE;
        end
`ifdef SNOOP_TIMEOUT_EN
        else if (tmo_last) begin
          state_nxt = S_DONE;
          tmo_fire  = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_nxt  = S_IDLE;
        done       = grant;
        fill_state = fill_of(snoop_op, hit_m);
`ifdef SNOOP_TIMEOUT_EN
        if (timed_out) begin
          fill_state = MESI_I;
          err        = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Owner latch, grant, snoop latency count, sharer capture and RR pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= 4'b0000;
      rr_ptr     <= 2'd3;
      snoop_src  <= 2'd0;
      snoop_op   <= 2'b00;
      snoop_addr <= '0;
      lat_cnt    <= 4'd0;
      hit_m      <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          lat_cnt <= 4'd0;
          if (pick[2]) begin
            grant      <= 4'b0001 << pick[1:0];
            snoop_src  <= pick[1:0];
            snoop_op   <= pick_op;
            snoop_addr <= pick_addr;
          end
        end
        S_SNOOP: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_last) hit_m <= snoop_hit & ~grant;
        end
        S_DONE: begin
          rr_ptr <= snoop_src;
          grant  <= 4'b0000;
        end
        default: ;
      endcase
    end
  end

`ifdef SNOOP_TIMEOUT_EN
  // Watchdog: restarts on every entry to WB or MEM, flags the DONE it forces.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= tmo_fire;
      if ((state_nxt == S_WB || state_nxt == S_MEM) && state_nxt != state)
        tmo_cnt <= '0;
      else if (state == S_WB || state == S_MEM)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Testbench for snoop_bus_arbiter: directed vector table, randomized
// transactions against a timeline model, arbitration order and async reset.
module tb_snoop_bus_arbiter;

  localparam int ADDR_W      = 12;
  localparam int SNOOP_LAT   = 2;
  localparam int TIMEOUT_CYC = 10;
  localparam int AW4         = 4 * ADDR_W;

  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] RDX = 2'b10;
  localparam logic [1:0] UPG = 2'b11;
  localparam logic [1:0] FM  = 2'b00;
  localparam logic [1:0] FE  = 2'b01;
  localparam logic [1:0] FS  = 2'b10;
  localparam logic [1:0] FI  = 2'b11;

  localparam logic [24:0] IDLE_OBS = {4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 2'b11, 1'b0};

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req;
  logic [7:0]        req_op;
  logic [AW4-1:0]    req_addr;
  logic [3:0]        grant;
  logic              snoop_valid;
  logic [1:0]        snoop_op;
  logic [ADDR_W-1:0] snoop_addr;
  logic [1:0]        snoop_src;
  logic [3:0]        snoop_hit;
  logic [3:0]        snoop_dirty;
  logic              wb_done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [3:0]        done;
  logic [1:0]        fill_state;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int                core;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        hit;
    logic [3:0]        dirty;
    int                wbw;
    int                memw;
    logic [1:0]        exp_fill;
    int                exp_tdone;
  } vec_t;

  vec_t tbl[7];

  snoop_bus_arbiter #(
    .ADDR_W(ADDR_W), .SNOOP_LAT(SNOOP_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .grant(grant), .snoop_valid(snoop_valid), .snoop_op(snoop_op),
    .snoop_addr(snoop_addr), .snoop_src(snoop_src), .snoop_hit(snoop_hit),
    .snoop_dirty(snoop_dirty), .wb_done(wb_done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .done(done),
    .fill_state(fill_state), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] obs();
    return {grant, snoop_valid, mem_req, mem_addr, done, fill_state, err};
  endfunction

  // Reference timeline from the protocol rules: snoop window, optional
  // writeback, optional fill, then one DONE cycle.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [3:0] g;
    r = v;
    g = 4'b0001 << v.core;
    r.exp_fill  = (v.op == RD) ? (((v.hit & ~g) != 4'b0000) ? FS : FE) : FM;
    r.exp_tdone = SNOOP_LAT + 2
                + (((v.dirty & ~g) != 4'b0000) ? v.wbw + 1 : 0)
                + ((v.op != UPG) ? v.memw + 1 : 0);
    return r;
  endfunction

  task automatic zero_inputs();
    req = 4'b0000; req_op = 8'h00; req_addr = '0;
    snoop_hit = 4'b0000; snoop_dirty = 4'b0000; wb_done = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One transaction from an idle arbiter; compares outputs every cycle.
  task automatic run_txn(input vec_t v, input bit noise, input bit tmo, input string nm);
    logic [3:0]        g;
    logic [3:0]        others;
    bit                dirty;
    bit                need_mem;
    int                n_mem;
    int                t_mem0;
    logic [3:0]        e_grant;
    logic              e_mr;
    logic [ADDR_W-1:0] e_ma;
    logic [3:0]        e_done;
    logic [1:0]        e_fill;
    logic              e_err;
    g        = 4'b0001 << v.core;
    dirty    = (v.dirty & ~g) != 4'b0000;
    need_mem = (v.op != UPG);
    n_mem    = tmo ? TIMEOUT_CYC : (need_mem ? v.memw + 1 : 0);
    t_mem0   = v.exp_tdone - n_mem;

    @(negedge clk);
    check({nm, " idle"}, obs(), IDLE_OBS);
    req         = g;
    req_op      = 8'(v.op) << (2 * v.core);
    req_addr    = AW4'(v.addr) << (ADDR_W * v.core);
    snoop_hit   = v.hit;
    snoop_dirty = v.dirty;

    for (int k = 1; k <= v.exp_tdone + 1; k++) begin
      @(negedge clk);
      // Stray pulses in the first snoop cycle must be ignored.
      wb_done = (k == 1) || (dirty && k == t_mem0 - 1);
      mem_ack = (k == 1) || (!tmo && need_mem && k == v.exp_tdone - 1);
      if (noise && k <= v.exp_tdone) begin
        others   = 4'($urandom) & ~g;
        req      = others | ((k >= 2 && $urandom_range(1) == 1) ? 4'b0000 : g);
        req_op   = 8'($urandom);
        req_addr = AW4'({$urandom, $urandom});
      end
      if (k == v.exp_tdone + 1) req = 4'b0000;

      e_grant = (k <= v.exp_tdone) ? g : 4'b0000;
      e_mr    = need_mem && k >= t_mem0 && k < v.exp_tdone;
      e_ma    = e_mr ? v.addr : '0;
      e_done  = (k == v.exp_tdone) ? g : 4'b0000;
      e_fill  = (k == v.exp_tdone) ? (tmo ? FI : v.exp_fill) : FI;
      e_err   = tmo && (k == v.exp_tdone);
      check($sformatf("%s cyc%0d", nm, k), obs(),
            {e_grant, (k == 1), e_mr, e_ma, e_done, e_fill, e_err});
      if (k == 1)
        check({nm, " latch"}, {snoop_src, snoop_op, snoop_addr}, {2'(v.core), v.op, v.addr});
    end
    wb_done = 1'b0;
    mem_ack = 1'b0;
  endtask

  // All cores hold req from reset; grant order follows the rotating pointer.
  task automatic rr_seq(input logic [7:0] ops, input string nm);
    int         exp_q[$];
    int         p;
    int         got;
    int         cyc;
    logic [3:0] el;
    reset = 1'b0;
    zero_inputs();
    req = 4'b1111; req_op = ops; req_addr = AW4'(48'h321_654_987_ABC);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) el[i] = (ops[2*i +: 2] != 2'b00);
    p = 3;
    for (int n = 0; n < 5; n++) begin
      for (int d = 1; d <= 4; d++) begin
        if (el[(p + d) % 4]) begin
          exp_q.push_back((p + d) % 4);
          p = (p + d) % 4;
          break;
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (snoop_valid) begin
        check($sformatf("%s grant%0d", nm, got), grant, 4'b0001 << exp_q[got]);
        got++;
      end
    end
    check({nm, " grant count"}, got, 5);
    zero_inputs();
  endtask

  // Reset asserted while the fill is outstanding: outputs clear at once, no done.
  task automatic mid_reset();
    do_reset();
    @(negedge clk);
    req = 4'b0001; req_op = {6'b0, RD}; req_addr = AW4'(12'h5A5);
    repeat (6) @(negedge clk);
    check("midrst before mem_req", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1 check("midrst async clear", {obs(), snoop_src, snoop_op, snoop_addr},
             {IDLE_OBS, 2'b00, 2'b00, 12'h000});
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst after cyc%0d", k), obs(), IDLE_OBS);
    end
  endtask

  initial begin
    reset = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    check("reset outputs", {obs(), snoop_src, snoop_op, snoop_addr},
          {IDLE_OBS, 2'b00, 2'b00, 12'h000});
    reset = 1'b1;

    //          core op   addr     hit      dirty    wbw memw fill tdone
    tbl[0] = '{2, RD,  12'h123, 4'b0000, 4'b0000, 0, 0, FE, 5};
    tbl[1] = '{0, RD,  12'h040, 4'b1000, 4'b0000, 0, 0, FS, 5};
    tbl[2] = '{1, RDX, 12'hABC, 4'b0001, 4'b0001, 3, 2, FM, 11};
    tbl[3] = '{3, UPG, 12'hFFF, 4'b0011, 4'b0000, 0, 0, FM, 4};
    tbl[4] = '{2, RD,  12'h555, 4'b0100, 4'b0100, 0, 0, FE, 5};
    tbl[5] = '{0, UPG, 12'h00F, 4'b0101, 4'b0100, 1, 0, FM, 6};
    tbl[6] = '{3, RD,  12'h7A0, 4'b0010, 4'b0010, 0, 4, FS, 10};
    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.core      = int'($urandom_range(3));
      v.op        = 2'($urandom_range(3, 1));
      v.addr      = ADDR_W'($urandom);
      v.hit       = 4'($urandom);
      v.dirty     = 4'($urandom);
      v.wbw       = int'($urandom_range(3));
      v.memw      = int'($urandom_range(3));
      v.exp_fill  = FI;
      v.exp_tdone = 0;
      v = model(v);
      run_txn(v, (i % 4) != 0, 1'b0, $sformatf("rnd%0d", i));
    end

    mid_reset();
    rr_seq(8'b01_01_01_01, "rr_all");
    rr_seq(8'b01_01_00_01, "rr_skip1");

`ifdef SNOOP_TIMEOUT_EN
    begin
      vec_t v;
      do_reset();
      v = '{1, RD, 12'h3C3, 4'b0000, 4'b0000, 0, 0, FI, SNOOP_LAT + 2 + TIMEOUT_CYC};
      run_txn(v, 1'b0, 1'b1, "tmo_mem");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
